// File: rtl/ps2_mouse_tracker_pkg.sv
// ps2_pkg: shared constants, packet struct and decode helper for the PS/2 mouse tracker
package ps2_pkg;
   localparam int PKT_BTN_L  = 0;
   localparam int PKT_BTN_R  = 1;
   localparam int PKT_BTN_M  = 2;
   localparam int PKT_SYNC   = 3;
   localparam int PKT_X_SIGN = 4;
   localparam int PKT_Y_SIGN = 5;
   localparam int PKT_X_OVF  = 6;
   localparam int PKT_Y_OVF  = 7;
   localparam int BYTE_W     = 8;
   localparam int STAT_LSB   = 0;
   localparam int X_LSB      = 8;
   localparam int Y_LSB      = 16;
   localparam int PKT_ERR_MAX = 255;
   typedef struct packed {
      logic [2:0] btn;
      logic [8:0] dx;
      logic [8:0] dy;
      logic       vld;
   } ps2_mouse_pkt_t;
   // An overflowed axis contributes no movement; a packet without sync is never valid.
   function automatic ps2_mouse_pkt_t decode(input logic [23:0] data, input logic stb);
      ps2_mouse_pkt_t p;
      logic [BYTE_W-1:0] st;
      st    = data[STAT_LSB +: BYTE_W];
      p.btn = st[PKT_BTN_M:PKT_BTN_L];
      p.dx  = st[PKT_X_OVF] ? '0 : {st[PKT_X_SIGN], data[X_LSB +: BYTE_W]};
      p.dy  = st[PKT_Y_OVF] ? '0 : {st[PKT_Y_SIGN], data[Y_LSB +: BYTE_W]};
      p.vld = stb & st[PKT_SYNC];
      return p;
   endfunction
endpackage

// File: rtl/ps2_mouse_tracker_if.sv
// ps2_mouse_tracker_if: packet input and cursor output bundle of the mouse tracker
interface ps2_mouse_tracker_if #(parameter int POS_W = 8);
   logic             ps2pkt_vld;
   logic [23:0]      ps2pkt_data;
   logic             init_done;
   logic [POS_W-1:0] mouse_x;
   logic [POS_W-1:0] mouse_y;
   logic [2:0]       mouse_btn;
   logic             mouse_vld;
   logic [7:0]       pkt_err_cnt;
   modport master (
      output ps2pkt_vld, ps2pkt_data, init_done,
      input  mouse_x, mouse_y, mouse_btn, mouse_vld, pkt_err_cnt
   );
   modport slave (
      input  ps2pkt_vld, ps2pkt_data, init_done,
      output mouse_x, mouse_y, mouse_btn, mouse_vld, pkt_err_cnt
   );
endinterface

// File: rtl/ps2_axis_accum.sv
// ps2_axis_accum: one axis of cursor position, signed accumulate with clamp to [0, MAX]
module ps2_axis_accum #(
   parameter int POS_W  = 8,
   parameter int MAX    = 159,
   parameter int INIT   = 80,
   parameter bit INVERT = 1'b0
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic              init_done_i,
   input  logic              upd_i,
   input  logic signed [8:0] delta_i,
   output logic [POS_W-1:0]  pos_o
);
   localparam int W = POS_W + 2;
   localparam logic signed [W-1:0] MAX_S = W'(MAX);
   logic [POS_W-1:0] pos_d, pos_q;
   logic signed [W-1:0] cur, dlt, sum;
   always_comb begin
      cur   = signed'(W'(pos_q));
      dlt   = W'(delta_i);
      sum   = INVERT ? cur - dlt : cur + dlt;
      pos_d = !init_done_i ? POS_W'(INIT) :
              !upd_i       ? pos_q :
              sum < 0      ? '0 :
              sum > MAX_S  ? POS_W'(MAX) : sum[POS_W-1:0];
   end
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) pos_q <= POS_W'(INIT);
      else        pos_q <= pos_d;
   end
   assign pos_o = pos_q;
endmodule

// File: rtl/ps2_mouse_tracker.sv
// ps2_mouse_tracker: decodes PS/2 mouse packets into a clamped cursor position and buttons
module ps2_mouse_tracker
   import ps2_pkg::*;
#(
   parameter int POS_W    = 8,
   parameter int X_MAX    = 159,
   parameter int Y_MAX    = 119,
   parameter int X_INIT   = 80,
   parameter int Y_INIT   = 60,
   parameter bit Y_INVERT = 1'b1
) (
   input  logic clk_sys,
   input  logic rst_n,
   ps2_mouse_tracker_if.slave bus
);
   ps2_mouse_pkt_t pkt_d, pkt_q;
   logic [7:0] err_d, err_q;
   logic [2:0] btn_d, btn_q;
   logic       vld_d, vld_q;
   logic       bad;
   logic [POS_W-1:0] x, y;
   // Stage-1 valid is gated by init_done so dropping it also discards any in-flight packet.
   always_comb begin
      pkt_d = decode(bus.ps2pkt_data, bus.ps2pkt_vld & bus.init_done);
      bad   = bus.init_done & bus.ps2pkt_vld & ~bus.ps2pkt_data[PKT_SYNC];
      err_d = (bad && err_q != 8'(PKT_ERR_MAX)) ? err_q + 8'd1 : err_q;
      btn_d = !bus.init_done ? 3'b000 : pkt_q.vld ? pkt_q.btn : btn_q;
      vld_d = bus.init_done & pkt_q.vld;
   end
   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         pkt_q <= '0;
         err_q <= '0;
         btn_q <= '0;
         vld_q <= 1'b0;
      end else begin
         pkt_q <= pkt_d;
         err_q <= err_d;
         btn_q <= btn_d;
         vld_q <= vld_d;
      end
   end
   ps2_axis_accum #(.POS_W(POS_W), .MAX(X_MAX), .INIT(X_INIT), .INVERT(1'b0)) u_x (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .init_done_i(bus.init_done),
      .upd_i      (pkt_q.vld),
      .delta_i    (pkt_q.dx),
      .pos_o      (x)
   );
   ps2_axis_accum #(.POS_W(POS_W), .MAX(Y_MAX), .INIT(Y_INIT), .INVERT(Y_INVERT)) u_y (
      .clk_sys    (clk_sys),
      .rst_n      (rst_n),
      .init_done_i(bus.init_done),
      .upd_i      (pkt_q.vld),
      .delta_i    (pkt_q.dy),
      .pos_o      (y)
   );
   assign bus.mouse_x     = x;
   assign bus.mouse_y     = y;
   assign bus.mouse_btn   = btn_q;
   assign bus.mouse_vld   = vld_q;
   assign bus.pkt_err_cnt = err_q;
endmodule

// File: tb/tb_ps2_mouse_tracker.sv
// tb_ps2_mouse_tracker: directed scoreboard bench for the PS/2 mouse tracker
module tb_ps2_mouse_tracker;
   typedef struct {int due; int x; int y; int btn;} exp_t;
   logic clk = 1'b0;
   logic rst_n;
   int compared = 0;
   int mism = 0;
   int cyc = 0;
   int mx = 80;
   int my = 60;
   int merr = 0;
   exp_t ex_q[$];
   ps2_mouse_tracker_if #(.POS_W(8)) bus();
   ps2_mouse_tracker dut (.clk_sys(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic int clamp(int v, int m);
      return v < 0 ? 0 : (v > m ? m : v);
   endfunction
   task automatic chk(string tag, int obs, int expv);
      compared++;
      assert (obs === expv) else begin
         mism++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask
   task automatic tick();
      exp_t e;
      bit due;
      @(posedge clk);
      #1;
      cyc++;
      due = ex_q.size() > 0 && ex_q[0].due == cyc;
      if (bus.mouse_vld === 1'b1) begin
         compared++;
         assert (due) else begin
            mism++;
            $error("FAIL vld_unexpected: observed 1 expected 0 at cycle %0d", cyc);
         end
         if (due) begin
            e = ex_q.pop_front();
            chk("sb_x", int'(bus.mouse_x), e.x);
            chk("sb_y", int'(bus.mouse_y), e.y);
            chk("sb_btn", int'(bus.mouse_btn), e.btn);
         end
      end else if (due) begin
         compared++;
         assert (bus.mouse_vld === 1'b1) else begin
            mism++;
            $error("FAIL vld_missing: observed %b expected 1 at cycle %0d", bus.mouse_vld, cyc);
         end
         void'(ex_q.pop_front());
      end
   endtask
   task automatic send(logic [23:0] d);
      int dx, dy;
      bus.ps2pkt_vld  = 1'b1;
      bus.ps2pkt_data = d;
      if (bus.init_done) begin
         if (d[3]) begin
            dx = d[6] ? 0 : (d[4] ? int'(d[15:8]) - 256 : int'(d[15:8]));
            dy = d[7] ? 0 : (d[5] ? int'(d[23:16]) - 256 : int'(d[23:16]));
            mx = clamp(mx + dx, 159);
            my = clamp(my - dy, 119);
            ex_q.push_back('{cyc + 2, mx, my, int'(d[2:0])});
         end else if (merr < 255) merr++;
      end
      tick();
      bus.ps2pkt_vld = 1'b0;
   endtask
   task automatic reinit();
      bus.init_done = 1'b0;
      tick();
      bus.init_done = 1'b1;
      mx = 80;
      my = 60;
   endtask
   initial begin
      rst_n = 1'b0;
      bus.init_done = 1'b0;
      bus.ps2pkt_vld = 1'b0;
      bus.ps2pkt_data = '0;
      tick();
      chk("rst_x", int'(bus.mouse_x), 80);
      chk("rst_y", int'(bus.mouse_y), 60);
      chk("rst_btn", int'(bus.mouse_btn), 0);
      chk("rst_vld", int'(bus.mouse_vld), 0);
      chk("rst_err", int'(bus.pkt_err_cnt), 0);
      rst_n = 1'b1;
      tick();
      // Packets while not initialised must be ignored, including bad-sync ones.
      send(24'h050A09);
      send(24'h050A09);
      send(24'h000001);
      tick();
      chk("noinit_x", int'(bus.mouse_x), 80);
      chk("noinit_y", int'(bus.mouse_y), 60);
      chk("noinit_btn", int'(bus.mouse_btn), 0);
      chk("noinit_err", int'(bus.pkt_err_cnt), 0);
      bus.init_done = 1'b1;
      tick();
      send(24'h050A09);
      tick();
      chk("p2_x", int'(bus.mouse_x), 90);
      chk("p2_y", int'(bus.mouse_y), 55);
      chk("p2_btn", int'(bus.mouse_btn), 1);
      tick();
      chk("p2_vld_once", int'(bus.mouse_vld), 0);
      reinit();
      send(24'h00F618);
      tick();
      chk("p3_x", int'(bus.mouse_x), 70);
      send(24'h008018);
      send(24'h008018);
      tick();
      chk("p3_clamp0", int'(bus.mouse_x), 0);
      reinit();
      send(24'h007F08);
      send(24'h007F08);
      send(24'h007F08);
      tick();
      tick();
      chk("p4_clampmax", int'(bus.mouse_x), 159);
      chk("p4_drained", ex_q.size(), 0);
      reinit();
      send(24'h037F48);
      tick();
      chk("p5_ovf_x", int'(bus.mouse_x), 80);
      chk("p5_ovf_y", int'(bus.mouse_y), 57);
      send(24'h000001);
      chk("p5_err1", int'(bus.pkt_err_cnt), 1);
      tick();
      chk("p5_err_novld", int'(bus.mouse_vld), 0);
      for (int i = 0; i < 299; i++) send(24'h000001);
      tick();
      chk("p5_err_sat", int'(bus.pkt_err_cnt), 255);
      chk("p5_err_model", int'(bus.pkt_err_cnt), merr);
      reinit();
      send(24'h050A09);
      bus.init_done = 1'b0;
      void'(ex_q.pop_back());
      mx = 80;
      my = 60;
      tick();
      chk("p6_drop_x", int'(bus.mouse_x), 80);
      chk("p6_drop_y", int'(bus.mouse_y), 60);
      chk("p6_drop_btn", int'(bus.mouse_btn), 0);
      chk("p6_err_kept", int'(bus.pkt_err_cnt), 255);
      bus.init_done = 1'b1;
      send(24'h050A09);
      tick();
      chk("p6_again_x", int'(bus.mouse_x), 90);
      send(24'h050A09);
      #3;
      rst_n = 1'b0;
      void'(ex_q.pop_back());
      #1;
      chk("arst_x", int'(bus.mouse_x), 80);
      chk("arst_y", int'(bus.mouse_y), 60);
      chk("arst_btn", int'(bus.mouse_btn), 0);
      chk("arst_vld", int'(bus.mouse_vld), 0);
      chk("arst_err", int'(bus.pkt_err_cnt), 0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("arst_hold_x", int'(bus.mouse_x), 80);
      chk("drain", ex_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
      $finish;
   end
endmodule
